// File: rtl/daq_pkg.sv
// Shared types and default widths for the high-speed DAQ controller datapath.
// Used by the conversion sequencer, the sample FIFO and timestamp consumers.
package daq_pkg;

    localparam int unsigned DAQ_ADC_WIDTH       = 12;
    localparam int unsigned DAQ_CHANNEL_WIDTH   = 4;
    localparam int unsigned DAQ_TIMESTAMP_WIDTH = 32;
    localparam int unsigned DAQ_CONV_TIMEOUT    = 64;
    localparam int unsigned DAQ_ERR_CNT_WIDTH   = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        OUTPUT
    } seq_state_t;

    typedef struct packed {
        logic [DAQ_TIMESTAMP_WIDTH-1:0] timestamp;
        logic [DAQ_CHANNEL_WIDTH-1:0]   channel;
        logic [DAQ_ADC_WIDTH-1:0]       data;
    } daq_sample_t;

    // Bits needed to count 0 .. timeout-1; never narrower than one bit.
    function automatic int unsigned wait_cnt_width(input int unsigned timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/daq_timestamp_counter.sv
// Free-running wrap-around counter; the shared time base for sample stamping.
// Counts every cycle from reset release and is never gated.
module daq_timestamp_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/adc_conv_sequencer.sv
// Drives one ADC conversion per arbiter grant, waits for done with a timeout,
// and hands the stamped sample to the FIFO over valid/ready.
module adc_conv_sequencer
    import daq_pkg::*;
#(
    parameter int unsigned ADC_WIDTH       = DAQ_ADC_WIDTH,
    parameter int unsigned CHANNEL_WIDTH   = DAQ_CHANNEL_WIDTH,
    parameter int unsigned TIMESTAMP_WIDTH = DAQ_TIMESTAMP_WIDTH,
    parameter int unsigned CONV_TIMEOUT    = DAQ_CONV_TIMEOUT,
    parameter int unsigned ERR_CNT_WIDTH   = DAQ_ERR_CNT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       req_valid,
    input  logic [CHANNEL_WIDTH-1:0]   req_channel,
    output logic                       req_ready,
    output logic                       adc_start_conv,
    output logic [CHANNEL_WIDTH-1:0]   adc_channel_sel,
    input  logic                       adc_conv_done,
    input  logic [ADC_WIDTH-1:0]       adc_data,
    input  logic                       adc_busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADC_WIDTH-1:0]       out_data,
    output logic [CHANNEL_WIDTH-1:0]   out_channel,
    output logic [TIMESTAMP_WIDTH-1:0] out_timestamp,
    output logic                       timeout_err,
    output logic [ERR_CNT_WIDTH-1:0]   timeout_count,
    output logic                       seq_busy
);

    localparam int unsigned WaitW = wait_cnt_width(CONV_TIMEOUT);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(CONV_TIMEOUT - 1);

    typedef struct packed {
        logic [TIMESTAMP_WIDTH-1:0] timestamp;
        logic [CHANNEL_WIDTH-1:0]   channel;
        logic [ADC_WIDTH-1:0]       data;
    } sample_t;

    seq_state_t                 state_q, state_d;
    logic [WaitW-1:0]           wait_cnt_q, wait_cnt_d;
    logic                       start_q, start_d;
    logic [CHANNEL_WIDTH-1:0]   chan_sel_q, chan_sel_d;
    sample_t                    sample_q, sample_d;
    logic                       valid_q, valid_d;
    logic [ERR_CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;

    logic [TIMESTAMP_WIDTH-1:0] ts_now;
    logic                       ready_int;
    logic                       accept;
    logic                       wait_expired;
    logic                       abort;

    daq_timestamp_counter #(
        .Width (TIMESTAMP_WIDTH)
    ) u_timestamp (
        .clk     (clk),
        .rst_n   (rst_n),
        .count_o (ts_now)
    );

    // rst_n is folded in so the grant path is quiet while reset is held.
    assign ready_int    = rst_n && (state_q == IDLE) && enable && !adc_busy;
    assign accept       = req_valid && ready_int;
    assign wait_expired = (wait_cnt_q == WaitLast);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        start_d    = 1'b0;
        chan_sel_d = chan_sel_q;
        sample_d   = sample_q;
        valid_d    = valid_q;
        err_cnt_d  = err_cnt_q;
        abort      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    chan_sel_d = req_channel;
                    start_d    = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                wait_cnt_d = '0;
                state_d    = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A done strobe on the final wait cycle still wins over the abort.
                if (adc_conv_done) begin
                    sample_d.timestamp = ts_now;
                    sample_d.channel   = chan_sel_q;
                    sample_d.data      = adc_data;
                    valid_d            = 1'b1;
                    state_d            = OUTPUT;
                end else if (wait_expired) begin
                    abort = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            start_q    <= 1'b0;
            chan_sel_q <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            start_q    <= start_d;
            chan_sel_q <= chan_sel_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign req_ready       = ready_int;
    assign adc_start_conv  = start_q;
    assign adc_channel_sel = chan_sel_q;
    assign out_valid       = valid_q;
    assign out_data        = sample_q.data;
    assign out_channel     = sample_q.channel;
    assign out_timestamp   = sample_q.timestamp;
    assign timeout_err     = abort;
    assign timeout_count   = err_cnt_q;
    assign seq_busy        = (state_q != IDLE);

endmodule
